axis_rr_arbiter: RTL
====================

Name: axis_rr_arbiter

Overview:
Packet-level round-robin arbiter that shares one AXI-Stream master port between NUM_INPUTS AXI-Stream slave ports. A grant is held for a whole packet, terminated by tlast, so packets never interleave. The block sits upstream of the shared stream datapath, typically feeding an AXIS register slice, and sequences which requester owns the output.

Parameters:
NUM_INPUTS, 4, number of requesting slave streams (2..16)
DATA_WIDTH, 32, tdata width in bits per stream
IDX_WIDTH, $clog2(NUM_INPUTS), width of the grant index (derived; do not override)

Ports:
clk  input  1  single clock; all logic rising-edge
reset_n  input  1  asynchronous, active-low reset
s_axis_tvalid  input  NUM_INPUTS  per-input valid; bit i belongs to input i
s_axis_tdata  input  NUM_INPUTS*DATA_WIDTH  packed data; input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
s_axis_tlast  input  NUM_INPUTS  per-input end-of-packet
s_axis_tready  output  NUM_INPUTS  per-input ready
m_axis_tvalid  output  1  shared output valid
m_axis_tdata  output  DATA_WIDTH  shared output data
m_axis_tlast  output  1  shared output end-of-packet
m_axis_tready  input  1  downstream ready
grant_idx  output  IDX_WIDTH  index of the currently or most recently granted input
grant_active  output  1  high while a packet grant is held

Behaviour:
- Reset (reset_n low, asynchronous assert, synchronous-release use): state=IDLE, grant_active=0, grant_idx=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0. Internal last-grant pointer resets to NUM_INPUTS-1, so input 0 has first priority.
- FSM states: IDLE and BUSY.
- IDLE:
  - All s_axis_tready=0 and m_axis_tvalid=0.
  - If any s_axis_tvalid bit is set, select the first set bit searching upward from pointer+1, wrapping modulo NUM_INPUTS.
  - Register the selection into grant_idx, set grant_active=1, and go to BUSY on the next edge.
  - This gives one cycle of arbitration latency from valid to output valid.
- BUSY:
  - m_axis_tvalid = s_axis_tvalid[g], m_axis_tdata = tdata[g], m_axis_tlast = tlast[g], where g = grant_idx.
  - s_axis_tready[g] = m_axis_tready; every other ready bit is 0.
  - Output is a combinational mux of registered grant state; there is no data storage.
- Transfer = m_axis_tvalid & m_axis_tready.
  - On a transfer with m_axis_tlast=1: pointer<=g, grant_active<=0, go to IDLE.
  - Exactly one idle bubble cycle separates consecutive packets.
- Grant is never revoked mid-packet. If s_axis_tvalid[g] drops mid-packet, stay in BUSY with m_axis_tvalid=0.
- Requests arriving during BUSY are not considered until IDLE.
- Simultaneous requests: strict rotation from pointer+1. The input that just finished has lowest priority in the next round.
- Single active requester: it is re-granted after every bubble cycle; no starvation of it.
- Single-beat packet (tlast on first beat): legal; BUSY lasts one transfer cycle.
- grant_idx holds its value through IDLE until the next grant.
- Reset mid-packet: immediate return to reset values. The partial packet is truncated; no tlast is emitted.
- AXIS rules on the output: tdata/tlast are stable while tvalid&~tready, provided the granted source obeys AXIS.

Optional Feature:
Macro AXIS_RR_ARB_OUT_REG_EN.
- Defined:
  - A 2-entry skid buffer (valid, data, last) is inserted between the mux and the m_axis outputs.
  - s_axis_tready[g] is driven from the skid buffer's registered "not full" flag, not from m_axis_tready, so there is no combinational path from m_axis_tready to s_axis_tready.
  - Adds 1 cycle of latency (valid to m_axis_tvalid = 2 cycles from IDLE).
  - Return to IDLE occurs when tlast is accepted into the buffer; the buffer drains independently.
  - Buffer resets empty.
  - Full throughput is sustained with m_axis_tready held high.
- Undefined: combinational output path exactly as in Behaviour.

Test Plan:
- Only input 2 valid with a 3-beat packet (tdata 0xA,0xB,0xC; tlast on C), m_axis_tready=1 -> grant_idx=2 one cycle after valid; outputs A,B,C on consecutive cycles with tlast on C; grant_active falls after C.
- Inputs 0,1,3 all valid with 2-beat packets continuously -> grant order 0,1,3,0,1,3; one bubble between packets; no interleaved beats.
- Input 1 granted, m_axis_tready toggled 1,0,0,1 -> beat held stable during stall; s_axis_tready[1] mirrors m_axis_tready; all other readies 0.
- Input 0 mid-packet with s_axis_tvalid[0] low for 3 cycles while input 1 valid -> grant stays 0, m_axis_tvalid=0 for those cycles, input 1 served only after tlast on 0.
- reset_n pulsed low after beat 2 of a 4-beat packet -> all outputs 0 asynchronously; after release, input 0 wins if inputs 0 and 2 are both valid.
- With AXIS_RR_ARB_OUT_REG_EN defined, the first scenario repeated -> first beat appears 2 cycles after valid; same data order; no data lost under random m_axis_tready.

Source files
------------

// File: rtl/axis_rr_arbiter_if.sv
// Stream bundle for axis_rr_arbiter: N slave lanes, one shared master lane,
// plus grant status. The arbiter connects through the slave modport.
interface axis_rr_arbiter_if #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = $clog2(NUM_INPUTS)
);
  logic [NUM_INPUTS-1:0]            s_axis_tvalid;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_INPUTS-1:0]            s_axis_tlast;
  logic [NUM_INPUTS-1:0]            s_axis_tready;
  logic                             m_axis_tvalid;
  logic [DATA_WIDTH-1:0]            m_axis_tdata;
  logic                             m_axis_tlast;
  logic                             m_axis_tready;
  logic [IDX_WIDTH-1:0]             grant_idx;
  logic                             grant_active;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast,
    output grant_idx, grant_active
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast,
    input  grant_idx, grant_active
  );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin AXI-Stream arbiter; grant held until tlast.
// Define AXIS_RR_ARB_OUT_REG_EN to add a 2-entry output skid buffer.
module axis_rr_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = $clog2(NUM_INPUTS)
) (
  input logic            clk,
  input logic            reset_n,
  axis_rr_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] grant_q, grant_d;
  logic [IDX_WIDTH-1:0] ptr_q, ptr_d;

  logic                  found;
  logic [IDX_WIDTH-1:0]  sel;
  int                    k;
  logic                  busy;
  logic                  src_valid;
  logic                  src_last;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  accept;

  // First requester above the last grant, wrapping
  always_comb begin
    found = 1'b0;
    sel   = '0;
    k     = 0;
    for (int i = 1; i <= NUM_INPUTS; i++) begin
      k = (int'(ptr_q) + i) % NUM_INPUTS;
      if (!found && bus.s_axis_tvalid[k]) begin
        found = 1'b1;
        sel   = IDX_WIDTH'(k);
      end
    end
  end

  assign busy      = (state_q == BUSY);
  assign src_valid = bus.s_axis_tvalid[grant_q];
  assign src_last  = bus.s_axis_tlast[grant_q];
  assign src_data  =
    bus.s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];

`ifdef AXIS_RR_ARB_OUT_REG_EN
  logic [DATA_WIDTH-1:0] skid_data_q [2];
  logic [1:0]            skid_last_q;
  logic                  wr_q, rd_q;
  logic [1:0]            cnt_q, cnt_d;
  logic                  nfull_q;
  logic                  pop;

  assign accept = busy & src_valid & nfull_q;
  assign pop    = (cnt_q != 2'd0) & bus.m_axis_tready;
  assign cnt_d  = cnt_q + {1'b0, accept} - {1'b0, pop};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_data_q[0] <= '0;
      skid_data_q[1] <= '0;
      skid_last_q    <= '0;
      wr_q           <= 1'b0;
      rd_q           <= 1'b0;
      cnt_q          <= 2'd0;
      nfull_q        <= 1'b1;
    end else begin
      if (accept) begin
        skid_data_q[wr_q] <= src_data;
        skid_last_q[wr_q] <= src_last;
        wr_q              <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q   <= cnt_d;
      nfull_q <= (cnt_d != 2'd2);
    end
  end

  always_comb begin
    bus.s_axis_tready = '0;
    if (busy) bus.s_axis_tready[grant_q] = nfull_q;
  end

  assign bus.m_axis_tvalid = (cnt_q != 2'd0);
  assign bus.m_axis_tdata  = skid_data_q[rd_q];
  assign bus.m_axis_tlast  = skid_last_q[rd_q] & (cnt_q != 2'd0);
`else
  assign accept = busy & src_valid & bus.m_axis_tready;

  always_comb begin
    bus.s_axis_tready = '0;
    if (busy) bus.s_axis_tready[grant_q] = bus.m_axis_tready;
  end

  assign bus.m_axis_tvalid = busy & src_valid;
  assign bus.m_axis_tdata  = busy ? src_data : '0;
  assign bus.m_axis_tlast  = busy & src_last;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          grant_d = sel;
        end
      end
      BUSY: begin
        if (accept && src_last) begin
          state_d = IDLE;
          ptr_d   = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= IDX_WIDTH'(NUM_INPUTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.grant_idx    = grant_q;
  assign bus.grant_active = busy;

endmodule
